// File: rtl/fetch_decode_stage.sv
// Fetch unit and IF/ID register: owns the PC, drives the synchronous instruction memory,
// and hands each fetched word to decode exactly once despite stalls, flushes and redirects.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [6:0]  opD,
    output logic [2:0]  funct3D,
    output logic        funct7b5D
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic        fv_q, fv_d;
    logic [31:0] fpc_q, fpc_d;
    logic        sv_q, sv_d;
    logic [31:0] spc_q, spc_d;
    logic [31:0] sinstr_q, sinstr_d;
    logic [31:0] instrD_q, instrD_d;
    logic [31:0] pcD_q, pcD_d;
    logic        validD_q, validD_d;
    logic        rel_q;
    logic        advance;

    // Release flop: the first edge after reset deasserts only arms the stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_q <= 1'b0;
        end else begin
            rel_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            pcf_q    <= RESET_PC;
            fv_q     <= 1'b0;
            fpc_q    <= 32'h0;
            sv_q     <= 1'b0;
            spc_q    <= 32'h0;
            sinstr_q <= NOP_INSTR;
            instrD_q <= NOP_INSTR;
            pcD_q    <= 32'h0;
            validD_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            fv_q     <= fv_d;
            fpc_q    <= fpc_d;
            sv_q     <= sv_d;
            spc_q    <= spc_d;
            sinstr_q <= sinstr_d;
            instrD_q <= instrD_d;
            pcD_q    <= pcD_d;
            validD_q <= validD_d;
        end
    end

    // The release cycle of HOLD already re-issues PCF so the restart leaves no bubble.
    assign imem_en = (state_q != HOLD) || !Stall;
    assign advance = (state_q == BOOT) || !Stall;

    always_comb begin
        state_d  = state_q;
        pcf_d    = pcf_q;
        fv_d     = fv_q;
        fpc_d    = fpc_q;
        sv_d     = sv_q;
        spc_d    = spc_q;
        sinstr_d = sinstr_q;
        instrD_d = instrD_q;
        pcD_d    = pcD_q;
        validD_d = validD_q;

        if (!rel_q) begin
            state_d  = BOOT;
            pcf_d    = RESET_PC;
            fv_d     = 1'b0;
            sv_d     = 1'b0;
            instrD_d = NOP_INSTR;
            pcD_d    = 32'h0;
            validD_d = 1'b0;
        end else if (PCSrcE) begin
            state_d  = BOOT;
            pcf_d    = {PCTargetE[31:2], 2'b00};
            fv_d     = 1'b0;
            sv_d     = 1'b0;
            instrD_d = NOP_INSTR;
            validD_d = 1'b0;
        end else if (advance) begin
            state_d = RUN;
            pcf_d   = pcf_q + 32'd4;
            fv_d    = 1'b1;
            fpc_d   = pcf_q;
            if (sv_q) begin
                instrD_d = sinstr_q;
                pcD_d    = spc_q;
                validD_d = 1'b1;
                sv_d     = fv_q;
                spc_d    = fpc_q;
                sinstr_d = imem_rdata;
            end else if (fv_q) begin
                instrD_d = imem_rdata;
                pcD_d    = fpc_q;
                validD_d = 1'b1;
            end else begin
                instrD_d = NOP_INSTR;
                validD_d = 1'b0;
            end
            if (FlushD) begin
                instrD_d = NOP_INSTR;
                validD_d = 1'b0;
            end
        end else begin
            // Stalled: park the word arriving from memory, drop the speculative fetch of PCF.
            state_d = HOLD;
            fv_d    = 1'b0;
            if (fv_q) begin
                sv_d     = 1'b1;
                spc_d    = fpc_q;
                sinstr_d = imem_rdata;
            end
            if (FlushD) begin
                instrD_d = NOP_INSTR;
                validD_d = 1'b0;
            end
        end
    end

    assign imem_addr = pcf_q;
    assign InstrD    = instrD_q;
    assign PCD       = pcD_q;
    assign PCPlus4D  = pcD_q + 32'd4;
    assign ValidD    = validD_q;
    assign opD       = instrD_q[6:0];
    assign funct3D   = instrD_q[14:12];
    assign funct7b5D = instrD_q[30];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios plus random stall/flush/redirect traffic,
// checked against a queue-based model of the fetched instruction stream.
module tb_fetch_decode_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        resetN, resetW;
    logic        stall, flushD, pcSrcE;
    logic [31:0] pcTargetE;
    logic [31:0] imemAddr, imemRdata, instrD, pcD, pcPlus4D;
    logic        imemEn, validD, funct7b5D;
    logic [6:0]  opD;
    logic [2:0]  funct3D;

    logic        zeroBit = 1'b0;
    logic [31:0] zeroWord = 32'h0;
    logic [31:0] wImemAddr, wImemRdata, wInstrD, wPcD, wPcPlus4D;
    logic        wImemEn, wValidD, wFunct7b5D;
    logic [6:0]  wOpD;
    logic [2:0]  wFunct3D;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: next fetch PC, words fetched but not yet delivered, decode contents.
    logic [31:0] mPc, mDecPc;
    logic [31:0] mQueue[$];
    bit          mDecValid, mBoot, mHold;
    int          mDead;

    always #5 clock = ~clock;

    fetch_decode_stage dut (
        .clk(clock), .reset(resetN), .Stall(stall), .FlushD(flushD), .PCSrcE(pcSrcE),
        .PCTargetE(pcTargetE), .imem_addr(imemAddr), .imem_en(imemEn), .imem_rdata(imemRdata),
        .InstrD(instrD), .PCD(pcD), .PCPlus4D(pcPlus4D), .ValidD(validD), .opD(opD),
        .funct3D(funct3D), .funct7b5D(funct7b5D)
    );

    fetch_decode_stage #(.RESET_PC(WRAP_PC)) dutWrap (
        .clk(clock), .reset(resetW), .Stall(zeroBit), .FlushD(zeroBit), .PCSrcE(zeroBit),
        .PCTargetE(zeroWord), .imem_addr(wImemAddr), .imem_en(wImemEn), .imem_rdata(wImemRdata),
        .InstrD(wInstrD), .PCD(wPcD), .PCPlus4D(wPcPlus4D), .ValidD(wValidD), .opD(wOpD),
        .funct3D(wFunct3D), .funct7b5D(wFunct7b5D)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a | 32'h13;
    endfunction

    // Synchronous instruction memories with one-cycle read latency.
    always_ff @(posedge clock) begin
        if (imemEn) imemRdata <= memWord(imemAddr);
        if (wImemEn) wImemRdata <= memWord(wImemAddr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        mPc = 32'h0;
        mDecPc = 32'h0;
        mDecValid = 1'b0;
        mBoot = 1'b1;
        mHold = 1'b0;
        mDead = 1;
        mQueue.delete();
    endtask

    task automatic advanceModel(input bit s, input bit f, input bit r, input logic [31:0] t);
        logic [31:0] head;
        if (mDead > 0) begin
            mDead--;
        end else if (r) begin
            mDecValid = 1'b0;
            mQueue.delete();
            mPc = t & ~32'h3;
            mBoot = 1'b1;
            mHold = 1'b0;
        end else if (s && !mBoot) begin
            if (f) mDecValid = 1'b0;
            mHold = 1'b1;
        end else begin
            mBoot = 1'b0;
            mHold = 1'b0;
            if (mQueue.size() > 0) begin
                head = mQueue.pop_front();
                mDecValid = !f;
                if (!f) mDecPc = head;
            end else begin
                mDecValid = 1'b0;
            end
            mQueue.push_back(mPc);
            mPc = mPc + 32'd4;
        end
    endtask

    task automatic checkAll();
        logic [31:0] expInstr;
        expInstr = mDecValid ? memWord(mDecPc) : NOP;
        checkOutput("validD", 32'(validD), 32'(mDecValid));
        checkOutput("instrD", instrD, expInstr);
        checkOutput("opD", 32'(opD), 32'(expInstr[6:0]));
        checkOutput("funct3D", 32'(funct3D), 32'(expInstr[14:12]));
        checkOutput("funct7b5D", 32'(funct7b5D), 32'(expInstr[30]));
        if (mDecValid) begin
            checkOutput("pcD", pcD, mDecPc);
            checkOutput("pcPlus4D", pcPlus4D, mDecPc + 32'd4);
        end
        checkOutput("imemAddr", imemAddr, mPc);
        checkOutput("imemEn", 32'(imemEn), 32'(!(mHold && stall)));
    endtask

    // Drive one cycle of inputs, check at the falling edge, then step the model on the rising edge.
    task automatic applyStimulus(input bit s, input bit f, input bit r, input logic [31:0] t);
        stall = s;
        flushD = f;
        pcSrcE = r;
        pcTargetE = t;
        @(negedge clock);
        checkAll();
        @(posedge clock);
        advanceModel(s, f, r, t);
        #1;
    endtask

    task automatic runUntilPc(input logic [31:0] pc);
        int n = 0;
        while (!(mDecValid && mDecPc == pc) && n < 32) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            n++;
        end
        checkOutput("reachPc", pcD, pc);
    endtask

    task automatic checkWrap(input logic [31:0] expPc);
        checkOutput("wrapValid", 32'(wValidD), 32'h1);
        checkOutput("wrapPcD", wPcD, expPc);
        checkOutput("wrapPlus4", wPcPlus4D, expPc + 32'd4);
        checkOutput("wrapInstr", wInstrD, memWord(expPc));
    endtask

    initial begin
        resetN = 1'b0;
        resetW = 1'b0;
        stall = 1'b0;
        flushD = 1'b0;
        pcSrcE = 1'b0;
        pcTargetE = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rstValid", 32'(validD), 32'h0);
        checkOutput("rstInstr", instrD, NOP);
        checkOutput("rstPcD", pcD, 32'h0);
        checkOutput("rstPlus4", pcPlus4D, 32'h4);
        checkOutput("rstAddr", imemAddr, 32'h0);
        resetN = 1'b1;
        resetW = 1'b1;
        resetModel();

        // Start-up latency and sequential stream; the wrap instance runs in lockstep.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("noValidYet", 32'(validD), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("firstValid", 32'(validD), 32'h1);
        checkOutput("firstPcD", pcD, 32'h0);
        checkOutput("firstOp", 32'(opD), 32'h13);
        checkWrap(WRAP_PC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkWrap(32'hFFFF_FFFC);
        checkOutput("wrapPlus4Zero", wPcPlus4D, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkWrap(32'h0);

        // Three-cycle stall with PCD=8.
        runUntilPc(32'h8);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("holdPcf", imemAddr, 32'h10);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("holdPcD", pcD, 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("afterHold1", pcD, 32'hC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("afterHold2", pcD, 32'h10);

        // Redirect to 0x103 while PCD=4.
        resetN = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        resetModel();
        runUntilPc(32'h4);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h103);
        checkOutput("redirBubble", 32'(validD), 32'h0);
        checkOutput("redirNop", instrD, NOP);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redirFetch", imemAddr, 32'h104);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redirTarget", pcD, 32'h100);

        // Redirect together with Stall while in HOLD.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h2000);
        checkOutput("holdRedirBubble", 32'(validD), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("holdRedirPc", pcD, 32'h2000);

        // Single-cycle flush.
        runUntilPc(32'h2008);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flushBubble", 32'(validD), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("flushNext", pcD, 32'h2010);

        // Asynchronous reset in the middle of HOLD.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        stall = 1'b0;
        resetN = 1'b0;
        #1;
        checkOutput("asyncValid", 32'(validD), 32'h0);
        checkOutput("asyncInstr", instrD, NOP);
        checkOutput("asyncPcD", pcD, 32'h0);
        checkOutput("asyncPlus4", pcPlus4D, 32'h4);
        checkOutput("asyncAddr", imemAddr, 32'h0);
        checkOutput("asyncEn", 32'(imemEn), 32'h1);
        @(posedge clock);
        #1;
        resetN = 1'b1;
        resetModel();

        // Random traffic, including redirects near the top of the address space.
        for (int i = 0; i < 400; i++) begin
            bit s, f, r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus(s, f, r, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
